serial_pattern_detector: RTL and testbench
==========================================

// Module: serial_pattern_detector
// PURPOSE
//  Parametrised successor to the fixed two-bit serial pattern FSM.
//  - Detects a WIDTH-bit pattern on a serial bit stream sampled by an enable strobe.
//  - The pattern is loadable at run time.
//  - Overlapping or non-overlapping detection is selectable.
//  - Matches are counted, and a stretched match flag is provided for LED/seven-segment display.
//  - Sits between the slow-clock shift/stimulus logic and the board display logic.
// PARAMETERS
//  WIDTH            4        pattern length in bits, legal range 2..16
//  DEFAULT_PATTERN  4'b0110  pattern register value after reset, WIDTH bits
//  COUNT_WIDTH      8        width of saturating match counter
//  HOLD_TICKS       3        enable ticks that match_hold stays high after a match, >=1
// PORTS
//  clock        in   1                    single clock, all state on posedge
//  reset_n      in   1                    synchronous, active-low reset
//  enable       in   1                    sample strobe; in is consumed only when high
//  in           in   1                    serial data bit
//  load         in   1                    load pattern_in into pattern register
//  pattern_in   in   WIDTH                new pattern, MSB = oldest bit
//  overlap      in   1                    1 = overlapping detection, 0 = non-overlapping
//  match        out  1                    one-cycle pulse per detected pattern
//  match_hold   out  1                    stretched match flag
//  match_count  out  COUNT_WIDTH          saturating count of matches
//  history      out  WIDTH                last WIDTH sampled bits, LSB = newest
//  fill         out  $clog2(WIDTH+1)      valid bits in history since reset/load/match
// BEHAVIOUR
//  Reset (reset_n low at a posedge):
//   - history=0, fill=0, pattern=DEFAULT_PATTERN, match=0, match_hold=0, match_count=0, hold counter=0.
//   - Reset overrides every other input; reset mid-stream discards the partial pattern.
//  Load:
//   - load=1 at an edge: pattern<=pattern_in, fill<=0, history held, match<=0.
//   - load has priority over enable; a simultaneous sample is dropped.
//  Sample (enable=1, load=0):
//   - history<={history[WIDTH-2:0],in}.
//   - fill<=min(fill+1,WIDTH).
//  Match (registered, same edge as the completing sample):
//   - Condition: match<=1 iff enable & ~load & next_fill==WIDTH & next_history==pattern. Otherwise match<=0.
//   - Latency: match is high in the cycle immediately after the edge that shifted in the last pattern bit.
//  Overlap mode:
//   - overlap=1: fill stays WIDTH after a match, so the next sample may match again.
//   - overlap=0: on a match, fill<=0; WIDTH fresh samples are required before the next match.
//   - overlap is sampled at every edge; a change takes effect on the next sample.
//  match_count:
//   - Increments on every edge where match is set.
//   - Holds at 2**COUNT_WIDTH-1, no wrap.
//  Hold counter (0..HOLD_TICKS):
//   - Loaded with HOLD_TICKS on the edge that sets match; reload has priority over decrement.
//   - Otherwise decrements by 1 on each enable sample while nonzero.
//   - match_hold = (hold counter != 0): it rises together with match and falls after the HOLD_TICKS-th later sample.
//  Idle:
//   - enable=0 and load=0: all state is held and match=0.
// STRUCTURE
//  Shared package serial_pattern_pkg:
//   - Mode constants MODE_NONOVERLAP=1'b0, MODE_OVERLAP=1'b1.
//   - Legal WIDTH limits 2 and 16, used for elaboration checks.
//  Sub-module pulse_stretcher (parameter HOLD_TICKS; inputs clock, reset_n, trigger, tick; output active).
//   - Contains the hold counter.
//  Top level of this block:
//   - history/fill shift logic, pattern register, compare, and saturating counter.
// TESTING
//  1. Default 0110, overlap=1, enable every cycle, bits 0,1,1,0,1,1,0 -> match after bits 4 and 7, match_count=2.
//  2. Same stream, overlap=0 -> match after bit 4 only; then 0,1,1,0 appended -> second match, count=2.
//  3. Load 1111 then overlap=1 with six 1s -> match after bits 4,5,6. With overlap=0 -> match after bit 4 only.
//  4. fill=3, assert load and enable together -> sample dropped, fill=0, history unchanged, match=0.
//  5. COUNT_WIDTH=2, overlap=1, 1111 pattern, eight 1s -> count 1,2,3,3,3.
//     Same run: match_hold high for 3 samples after the last match, then low.
//  6. reset_n low for one edge with fill=3 and count=5 -> all outputs 0, pattern=0110.
//     No change occurs between edges (synchronous reset).

Source files
------------

// File: rtl/serial_pattern_pkg.sv
// Shared constants for the serial pattern detector: overlap mode encoding
// and the legal range of the pattern width.
package serial_pattern_pkg;

  typedef enum logic {
    MODE_NONOVERLAP = 1'b0,
    MODE_OVERLAP    = 1'b1
  } overlap_mode_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 16;

endpackage

// File: rtl/serial_pattern_detector_pulse_stretcher.sv
// Hold counter that keeps 'active' high for HOLD_TICKS ticks after a trigger.
// A trigger reloads the counter even while it is still running.
module pulse_stretcher #(
  parameter int unsigned HOLD_TICKS = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic trigger,
  input  logic tick,
  output logic active
);

  localparam int unsigned CW = $clog2(HOLD_TICKS + 1);

  if (HOLD_TICKS < 1) begin : g_bad_hold
    $error("pulse_stretcher: HOLD_TICKS must be at least 1");
  end

  logic [CW-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (trigger) begin
      count_q <= CW'(HOLD_TICKS);
    end else if (tick && count_q != '0) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign active = (count_q != '0);

endmodule

// File: rtl/serial_pattern_detector.sv
// Serial WIDTH-bit pattern detector with loadable pattern, selectable overlap,
// saturating match counter and stretched match flag for display.
module serial_pattern_detector
  import serial_pattern_pkg::*;
#(
  parameter int unsigned           WIDTH           = 4,
  parameter logic [WIDTH-1:0]      DEFAULT_PATTERN = 4'b0110,
  parameter int unsigned           COUNT_WIDTH     = 8,
  parameter int unsigned           HOLD_TICKS      = 3
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           in,
  input  logic                           load,
  input  logic [WIDTH-1:0]               pattern_in,
  input  logic                           overlap,
  output logic                           match,
  output logic                           match_hold,
  output logic [COUNT_WIDTH-1:0]         match_count,
  output logic [WIDTH-1:0]               history,
  output logic [$clog2(WIDTH+1)-1:0]     fill
);

  localparam int unsigned FILL_W = $clog2(WIDTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_pattern_detector: WIDTH out of legal range");
  end

  logic [WIDTH-1:0]  pattern_q;
  logic [WIDTH-1:0]  history_q;
  logic [WIDTH-1:0]  next_history;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] next_fill;
  logic              sample;
  logic              match_next;

  // Match is decided on the post-shift view so it registers on the same
  // edge that consumes the completing bit.
  always_comb begin
    sample       = enable & ~load;
    next_history = {history_q[WIDTH-2:0], in};
    next_fill    = (fill_q == FILL_W'(WIDTH)) ? fill_q : fill_q + FILL_W'(1);
    match_next   = sample && (next_fill == FILL_W'(WIDTH)) && (next_history == pattern_q);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pattern_q   <= DEFAULT_PATTERN;
      history_q   <= '0;
      fill_q      <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      match <= match_next;
      if (load) begin
        pattern_q <= pattern_in;
        fill_q    <= '0;
      end else if (enable) begin
        history_q <= next_history;
        fill_q    <= (match_next && overlap == MODE_NONOVERLAP) ? '0 : next_fill;
      end
      if (match_next && match_count != '1) begin
        match_count <= match_count + COUNT_WIDTH'(1);
      end
    end
  end

  pulse_stretcher #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_hold (
    .clock   (clock),
    .reset_n (reset_n),
    .trigger (match_next),
    .tick    (sample),
    .active  (match_hold)
  );

  assign history = history_q;
  assign fill    = fill_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Self-checking bench: directed scenarios plus random traffic against a
// sample-list reference model; two DUTs differ only in counter width.
module tb_serial_pattern_detector;

  localparam int W    = 4;
  localparam int HOLD = 3;

  logic       clock_50_mhz = 1'b0;
  logic       reset_n      = 1'b0;
  logic       enable       = 1'b0;
  logic       in_bit       = 1'b0;
  logic       load         = 1'b0;
  logic       overlap      = 1'b1;
  logic [3:0] pattern_in   = 4'b0000;

  logic       match_a, hold_a, match_b, hold_b;
  logic [7:0] count_a;
  logic [1:0] count_b;
  logic [3:0] hist_a, hist_b;
  logic [2:0] fill_a, fill_b;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_hist, m_fill, m_pat, m_count, m_since;
  bit m_match;

  always #10 clock_50_mhz = ~clock_50_mhz;

  serial_pattern_detector #(
    .WIDTH(4), .DEFAULT_PATTERN(4'b0110), .COUNT_WIDTH(8), .HOLD_TICKS(3)
  ) dut_a (
    .clock(clock_50_mhz), .reset_n(reset_n), .enable(enable), .in(in_bit),
    .load(load), .pattern_in(pattern_in), .overlap(overlap),
    .match(match_a), .match_hold(hold_a), .match_count(count_a),
    .history(hist_a), .fill(fill_a)
  );

  serial_pattern_detector #(
    .WIDTH(4), .DEFAULT_PATTERN(4'b0110), .COUNT_WIDTH(2), .HOLD_TICKS(3)
  ) dut_b (
    .clock(clock_50_mhz), .reset_n(reset_n), .enable(enable), .in(in_bit),
    .load(load), .pattern_in(pattern_in), .overlap(overlap),
    .match(match_b), .match_hold(hold_b), .match_count(count_b),
    .history(hist_b), .fill(fill_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      m_hist = 0; m_fill = 0; m_pat = 6; m_count = 0; m_since = HOLD; m_match = 0;
    end else if (load) begin
      m_pat = int'(pattern_in); m_fill = 0; m_match = 0;
    end else if (enable) begin
      m_hist  = ((m_hist << 1) | int'(in_bit)) & 15;
      m_fill  = (m_fill < W) ? m_fill + 1 : W;
      m_match = (m_fill == W) && (m_hist == m_pat);
      if (m_match) begin
        m_count++;
        m_since = 0;
        if (!overlap) m_fill = 0;
      end else if (m_since < HOLD) begin
        m_since++;
      end
    end else begin
      m_match = 0;
    end
  endtask

  task automatic check_all();
    check("match_a", 32'(match_a), 32'(m_match));
    check("hold_a",  32'(hold_a),  32'(m_since < HOLD));
    check("count_a", 32'(count_a), 32'((m_count > 255) ? 255 : m_count));
    check("hist_a",  32'(hist_a),  32'(m_hist));
    check("fill_a",  32'(fill_a),  32'(m_fill));
    check("match_b", 32'(match_b), 32'(m_match));
    check("hold_b",  32'(hold_b),  32'(m_since < HOLD));
    check("count_b", 32'(count_b), 32'((m_count > 3) ? 3 : m_count));
    check("hist_b",  32'(hist_b),  32'(m_hist));
    check("fill_b",  32'(fill_b),  32'(m_fill));
  endtask

  task automatic cycle(input logic rn, input logic en, input logic b, input logic ld,
                       input logic ov, input logic [3:0] pi);
    reset_n = rn; enable = en; in_bit = b; load = ld; overlap = ov; pattern_in = pi;
    model_edge();
    @(posedge clock_50_mhz);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
  endtask

  task automatic sample(input logic b, input logic ov);
    cycle(1'b1, 1'b1, b, 1'b0, ov, 4'b0000);
  endtask

  task automatic do_load(input logic [3:0] pi);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, pi);
  endtask

  initial begin
    logic [6:0]  s1;
    logic [10:0] s2;
    s1 = 7'b0110110;
    s2 = 11'b01101100110;

    // reset state
    do_reset();
    check("rst_match", 32'(match_a), 0);
    check("rst_count", 32'(count_a), 0);
    check("rst_fill",  32'(fill_a),  0);
    check("rst_hist",  32'(hist_a),  0);

    // 1: overlapping 0110 in 0110110
    for (int i = 0; i < 7; i++) begin
      sample(s1[6-i], 1'b1);
      check("t1_match", 32'(match_a), 32'(i == 3 || i == 6));
    end
    check("t1_count", 32'(count_a), 2);

    // 2: non-overlapping, then 0110 appended
    do_reset();
    for (int i = 0; i < 11; i++) begin
      sample(s2[10-i], 1'b0);
      check("t2_match", 32'(match_a), 32'(i == 3 || i == 10));
    end
    check("t2_count", 32'(count_a), 2);

    // 3: pattern 1111, overlap then non-overlap
    do_reset();
    do_load(4'b1111);
    for (int i = 0; i < 6; i++) begin
      sample(1'b1, 1'b1);
      check("t3_ov_match", 32'(match_a), 32'(i >= 3));
    end
    do_load(4'b1111);
    for (int i = 0; i < 6; i++) begin
      sample(1'b1, 1'b0);
      check("t3_nov_match", 32'(match_a), 32'(i == 3));
    end

    // 4: load wins over a simultaneous sample
    do_reset();
    sample(1'b1, 1'b1);
    sample(1'b0, 1'b1);
    sample(1'b1, 1'b1);
    check("t4_fill_pre", 32'(fill_a), 3);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
    check("t4_fill",  32'(fill_a),  0);
    check("t4_hist",  32'(hist_a),  5);
    check("t4_match", 32'(match_a), 0);

    // 5: 2-bit counter saturation and hold stretch
    do_reset();
    do_load(4'b1111);
    for (int i = 0; i < 8; i++) begin
      sample(1'b1, 1'b1);
      if (i >= 3) check("t5_count_b", 32'(count_b), 32'((i - 2 > 3) ? 3 : i - 2));
    end
    check("t5_hold0", 32'(hold_b), 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    check("t5_hold_idle", 32'(hold_b), 1);
    for (int j = 1; j <= 3; j++) begin
      sample(1'b0, 1'b1);
      check("t5_hold", 32'(hold_b), 32'(j < 3));
    end

    // 6: synchronous reset with fill=3, count=5
    do_reset();
    do_load(4'b1111);
    for (int i = 0; i < 8; i++) sample(1'b1, 1'b1);
    do_load(4'b1111);
    for (int i = 0; i < 3; i++) sample(1'b1, 1'b1);
    check("t6_count_pre", 32'(count_a), 5);
    check("t6_fill_pre",  32'(fill_a),  3);
    reset_n = 1'b0;
    #5;
    check("t6_fill_async",  32'(fill_a),  3);
    check("t6_count_async", 32'(count_a), 5);
    model_edge();
    @(posedge clock_50_mhz);
    #1;
    check_all();
    check("t6_fill",  32'(fill_a),  0);
    check("t6_count", 32'(count_a), 0);
    check("t6_hold",  32'(hold_a),  0);
    check("t6_hist",  32'(hist_a),  0);
    for (int i = 0; i < 4; i++) begin
      sample(s1[6-i], 1'b1);
      check("t6_default_pat", 32'(match_a), 32'(i == 3));
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 99) != 0),
            logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 19) == 0),
            logic'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
